// File: rtl/w4823_fp_pkg.sv
// w4823_fp_pkg: shared FP16 width, type, zero constant, default tap count and sequencer states
package w4823_fp_pkg;
   localparam int DW = 16;
   typedef logic [DW-1:0] fp16_t;
   localparam fp16_t FP16_ZERO = 16'h0000;
   localparam int NTAPS_DEF = 64;
   typedef enum logic {IDLE, RUN} tap_state_t;
endpackage

// File: rtl/w4823_fir_circbuf.sv
// w4823_fir_circbuf: NTAPS x DW circular sample store with wrapping write pointer and base-relative read
module w4823_fir_circbuf #(
   parameter int NTAPS = w4823_fp_pkg::NTAPS_DEF,
   parameter int AW    = $clog2(NTAPS),
   parameter int DW    = w4823_fp_pkg::DW
) (
   input  logic          clk2,
   input  logic          rst_n,
   input  logic          wr,
   input  logic [DW-1:0] wdata,
   input  logic          clr,
   input  logic [AW-1:0] rd_off,
   output logic [DW-1:0] rd_data
);
   import w4823_fp_pkg::*;
   logic [DW-1:0] mem [NTAPS];
   logic [AW-1:0] wptr;
   logic [AW-1:0] base;
   logic [AW-1:0] ra;
   assign ra = base - rd_off;
   assign rd_data = mem[ra];
   // write newest sample at wptr and remember it as the frame base; clear wipes the whole line
   always_ff @(posedge clk2 or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) mem[i] <= FP16_ZERO;
         wptr <= '0;
         base <= '0;
      end else if (clr) begin
         for (int i = 0; i < NTAPS; i++) mem[i] <= FP16_ZERO;
         wptr <= '0;
      end else if (wr) begin
         mem[wptr] <= wdata;
         base <= wptr;
         wptr <= wptr + 1'b1;
      end
endmodule

// File: rtl/w4823_fir_tap_seq.sv
// w4823_fir_tap_seq: streams NTAPS (sample, coefficient) FP16 pairs per accepted sample; optional flush port via W4823_TAPSEQ_FLUSH_EN
module w4823_fir_tap_seq #(
   parameter int NTAPS = w4823_fp_pkg::NTAPS_DEF,
   parameter int AW    = $clog2(NTAPS),
   parameter int DW    = w4823_fp_pkg::DW
) (
   input  logic          clk2,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          valid_in,
   output logic          ready_in,
   input  logic [DW-1:0] cin,
   input  logic [AW-1:0] caddr,
   input  logic          cload,
   output logic [DW-1:0] tap_x,
   output logic [DW-1:0] tap_c,
   output logic          tap_valid,
   input  logic          tap_ready,
   output logic          tap_first,
   output logic          tap_last,
   output logic          cload_err
`ifdef W4823_TAPSEQ_FLUSH_EN
   ,
   input  logic          flush
`endif
);
   import w4823_fp_pkg::*;
   tap_state_t state;
   logic [DW-1:0] coef [NTAPS];
   logic [AW-1:0] idx;
   logic [AW-1:0] idx_nx;
   logic [DW-1:0] rd_data;
   logic clr;
   logic accept;
   logic hs;
`ifdef W4823_TAPSEQ_FLUSH_EN
   assign clr = flush & (state == IDLE);
`else
   assign clr = 1'b0;
`endif
   assign ready_in = (state == IDLE) & ~clr;
   assign accept = valid_in & ready_in;
   assign hs = tap_valid & tap_ready;
   assign idx_nx = idx + 1'b1;

   w4823_fir_circbuf #(.NTAPS(NTAPS), .AW(AW), .DW(DW)) u_buf (
      .clk2    (clk2),
      .rst_n   (rst_n),
      .wr      (accept),
      .wdata   (din),
      .clr     (clr),
      .rd_off  (idx_nx),
      .rd_data (rd_data)
   );

   // coefficient writes only land while idle; a write attempted mid-frame is dropped and flagged
   always_ff @(posedge clk2 or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) coef[i] <= FP16_ZERO;
         cload_err <= 1'b0;
      end else if (cload) begin
         if (state == IDLE) coef[caddr] <= cin;
         else cload_err <= 1'b1;
      end

   // tap sequencer: tap 0 bypasses the sample write, later taps read the delay line behind the base
   always_ff @(posedge clk2 or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         tap_x <= FP16_ZERO;
         tap_c <= FP16_ZERO;
         tap_valid <= 1'b0;
         tap_first <= 1'b0;
         tap_last <= 1'b0;
      end else if (state == IDLE) begin
         if (accept) begin
            state <= RUN;
            idx <= '0;
            tap_x <= din;
            tap_c <= coef[0];
            tap_valid <= 1'b1;
            tap_first <= 1'b1;
            tap_last <= (NTAPS == 1);
         end
      end else if (hs) begin
         if (tap_last) begin
            state <= IDLE;
            tap_valid <= 1'b0;
            tap_first <= 1'b0;
            tap_last <= 1'b0;
         end else begin
            idx <= idx_nx;
            tap_x <= rd_data;
            tap_c <= coef[idx_nx];
            tap_first <= 1'b0;
            tap_last <= (idx_nx == AW'(NTAPS - 1));
         end
      end
endmodule

// File: tb/tb_w4823_fir_tap_seq.sv
// tb_w4823_fir_tap_seq: directed bench for the FIR tap sequencer with a sample-history and coefficient model
module tb_w4823_fir_tap_seq;
   localparam int NT = 64;
   logic clk2 = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] din = '0;
   logic valid_in = 1'b0;
   logic ready_in;
   logic [15:0] cin = '0;
   logic [5:0] caddr = '0;
   logic cload = 1'b0;
   logic [15:0] tap_x;
   logic [15:0] tap_c;
   logic tap_valid;
   logic tap_ready = 1'b1;
   logic tap_first;
   logic tap_last;
   logic cload_err;
`ifdef W4823_TAPSEQ_FLUSH_EN
   logic flush = 1'b0;
`endif
   int nvec = 0;
   int nerr = 0;
   logic [15:0] fx [NT];
   logic [15:0] fc [NT];
   logic [63:0] fmask;
   logic [63:0] lmask;
   int nhs;
   int stall_bad;
   int fcyc;
   logic [15:0] hist [$];
   logic [15:0] mc [NT];

   w4823_fir_tap_seq dut (
      .clk2      (clk2),
      .rst_n     (rst_n),
      .din       (din),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .cin       (cin),
      .caddr     (caddr),
      .cload     (cload),
      .tap_x     (tap_x),
      .tap_c     (tap_c),
      .tap_valid (tap_valid),
      .tap_ready (tap_ready),
      .tap_first (tap_first),
      .tap_last  (tap_last),
`ifdef W4823_TAPSEQ_FLUSH_EN
      .flush     (flush),
`endif
      .cload_err (cload_err)
   );

   always #5 clk2 = ~clk2;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cwrite(input logic [5:0] a, input logic [15:0] d);
      cload = 1'b1;
      caddr = a;
      cin = d;
      @(posedge clk2); #1;
      cload = 1'b0;
   endtask

   task automatic send(input logic [15:0] d, input bit cl = 1'b0, input logic [5:0] ca = '0,
                       input logic [15:0] cd = '0);
      int w = 0;
      while (!ready_in && w < 200) begin
         @(posedge clk2); #1;
         w++;
      end
      if (!ready_in) chk("ready_tmo", w, 0);
      din = d;
      valid_in = 1'b1;
      cload = cl;
      caddr = ca;
      cin = cd;
      @(posedge clk2); #1;
      valid_in = 1'b0;
      cload = 1'b0;
      hist.push_front(d);
      if (hist.size() > NT) void'(hist.pop_back());
   endtask

   task automatic run_frame(input bit stall, input bit junk);
      int n = 0;
      int cyc = 0;
      bit held = 1'b0;
      logic [34:0] saved = '0;
      fmask = '0;
      lmask = '0;
      stall_bad = 0;
      for (int k = 0; k < NT; k++) begin
         fx[k] = '0;
         fc[k] = '0;
      end
      forever begin
         if (held && {tap_x, tap_c, tap_valid, tap_first, tap_last} !== saved) stall_bad++;
         if (!tap_valid) break;
         tap_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (junk) begin
            valid_in = 1'b1;
            din = 16'($urandom);
         end
         held = !tap_ready;
         saved = {tap_x, tap_c, tap_valid, tap_first, tap_last};
         if (tap_ready && n < NT) begin
            fx[n] = tap_x;
            fc[n] = tap_c;
            fmask[n] = tap_first;
            lmask[n] = tap_last;
         end
         if (tap_ready) n++;
         @(posedge clk2); #1;
         cyc++;
         if (cyc > 4000) begin
            chk("frame_tmo", cyc, 4000);
            break;
         end
      end
      valid_in = 1'b0;
      tap_ready = 1'b1;
      nhs = n;
      fcyc = cyc;
   endtask

   task automatic check_frame();
      int bx = 0;
      int bc = 0;
      for (int k = 0; k < NT; k++) begin
         if (fx[k] !== (k < hist.size() ? hist[k] : 16'h0000)) bx++;
         if (fc[k] !== mc[k]) bc++;
      end
      chk("hs_count", nhs, NT);
      chk("x_seq_bad", bx, 0);
      chk("c_seq_bad", bc, 0);
      chk("first_mask", fmask, 64'h1);
      chk("last_mask", lmask, 64'h8000_0000_0000_0000);
      chk("stall_hold_bad", stall_bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < NT; k++) mc[k] = '0;
      repeat (3) @(posedge clk2);
      #1;
      chk("rst_tap_x", tap_x, 16'h0000);
      chk("rst_tap_c", tap_c, 16'h0000);
      chk("rst_tap_valid", tap_valid, 0);
      chk("rst_tap_first", tap_first, 0);
      chk("rst_tap_last", tap_last, 0);
      chk("rst_cload_err", cload_err, 0);
      chk("rst_ready_in", ready_in, 1);
      @(negedge clk2) rst_n = 1'b1;
      @(posedge clk2); #1;

      // coefficient ramp, then one impulse-like sample
      for (int k = 0; k < NT; k++) begin
         cwrite(6'(k), 16'(k));
         mc[k] = 16'(k);
      end
      send(16'h3C00);
      chk("t0_valid", tap_valid, 1);
      chk("t0_x", tap_x, 16'h3C00);
      chk("t0_c", tap_c, 16'h0000);
      chk("t0_first", tap_first, 1);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("ready_cycle", fcyc + 1, 65);
      chk("ready_back", ready_in, 1);

      // 66 samples: last frame must wrap around the pointer
      for (int n = 1; n <= 66; n++) begin
         send(16'(n));
         run_frame(1'b0, 1'b0);
         check_frame();
      end
      chk("wrap_newest", fx[0], 16'd66);
      chk("wrap_oldest", fx[63], 16'd3);

      // random back-pressure
      for (int f = 0; f < 3; f++) begin
         send(16'h1000 + 16'(f));
         run_frame(1'b1, 1'b0);
         check_frame();
      end

      // coefficient write during a frame is dropped and flagged
      send(16'h2000);
      tap_ready = 1'b0;
      cload = 1'b1;
      caddr = 6'd5;
      cin = 16'h4000;
      @(posedge clk2); #1;
      cload = 1'b0;
      chk("cload_err_set", cload_err, 1);
      run_frame(1'b0, 1'b0);
      check_frame();
      send(16'h2001);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("coef5_kept", fc[5], 16'd5);
      cwrite(6'd5, 16'h4000);
      mc[5] = 16'h4000;
      send(16'h2002);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("coef5_new", fc[5], 16'h4000);
      chk("cload_err_sticky", cload_err, 1);

      // valid_in held through a frame with changing din must not write
      send(16'h5A5A);
      run_frame(1'b0, 1'b1);
      check_frame();
      send(16'h6B6B);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("no_extra_write", fx[1], 16'h5A5A);

      // coefficient write on the acceptance edge
      send(16'h7000, 1'b1, 6'd0, 16'hABCD);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("coef0_old", fc[0], 16'h0000);
      mc[0] = 16'hABCD;
      send(16'h7001);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("coef0_new", fc[0], 16'hABCD);
      mc[7] = 16'h7777;
      send(16'h7002, 1'b1, 6'd7, 16'h7777);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("coef7_same_frame", fc[7], 16'h7777);

`ifdef W4823_TAPSEQ_FLUSH_EN
      for (int i = 0; i < 10; i++) begin
         send(16'h0100 + 16'(i));
         run_frame(1'b0, 1'b0);
      end
      flush = 1'b1;
      #1;
      chk("flush_ready_low", ready_in, 0);
      @(posedge clk2); #1;
      flush = 1'b0;
      hist.delete();
      send(16'h3C00);
      run_frame(1'b0, 1'b0);
      check_frame();
      chk("flush_cerr_kept", cload_err, 1);
`endif

      // reset in the middle of a frame
      send(16'h1234);
      repeat (20) begin
         @(posedge clk2); #1;
      end
      chk("mid_valid", tap_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_tap_x", tap_x, 16'h0000);
      chk("mrst_tap_c", tap_c, 16'h0000);
      chk("mrst_tap_valid", tap_valid, 0);
      chk("mrst_first_last", {tap_first, tap_last}, 2'b00);
      chk("mrst_ready_in", ready_in, 1);
      chk("mrst_cload_err", cload_err, 0);
      @(posedge clk2);
      @(negedge clk2) rst_n = 1'b1;
      @(posedge clk2); #1;
      hist.delete();
      for (int k = 0; k < NT; k++) mc[k] = '0;
      send(16'h3C00);
      run_frame(1'b0, 1'b0);
      check_frame();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
